// File: rtl/instr_decode_ctrl_pkg.sv
// Shared encodings for the instruction decode controller and the
// instruction generator: op/ext codes, ALU op codes, FSM states.
package instr_decode_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_CMP  = 4'b1011;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_PASS_B = 2'b01,
        ALU_CMP    = 2'b10,
        ALU_NOP    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_e;

    function automatic logic [15:0] ext_imm(
        input logic [7:0] imm,
        input logic       sext
    );
        return {{8{imm[7] & sext}}, imm};
    endfunction

endpackage

// File: rtl/instr_decode_ctrl_field_decode.sv
// idec_field_decode: combinational field decode of one instruction word.
// Ports: instr in; alu_op, imm_sel, writes, flag_upd, illegal, imm_out out.
module idec_field_decode
    import instr_decode_ctrl_pkg::*;
#(
    parameter bit IMM_SEXT = 1'b1
) (
    input  logic [15:0] instr,
    output alu_op_e     alu_op,
    output logic        imm_sel,
    output logic        writes,
    output logic        flag_upd,
    output logic        illegal,
    output logic [15:0] imm_out
);

    logic [3:0] op;
    logic [3:0] ext;
    logic       is_add;
    logic       is_mov;
    logic       is_cmp;
    logic       is_addi;

    assign op      = instr[15:12];
    assign ext     = instr[7:4];
    assign is_add  = (op == OP_RTYPE) && (ext == EXT_ADD);
    assign is_mov  = (op == OP_RTYPE) && (ext == EXT_MOV);
    assign is_cmp  = (op == OP_RTYPE) && (ext == EXT_CMP);
    assign is_addi = (op == OP_ADDI);
    assign imm_out = ext_imm(instr[7:0], IMM_SEXT);

    always_comb begin
        alu_op   = ALU_NOP;
        imm_sel  = 1'b0;
        writes   = 1'b0;
        flag_upd = 1'b0;
        illegal  = 1'b1;
        unique case (1'b1)
            is_add: begin
                alu_op   = ALU_ADD;
                writes   = 1'b1;
                flag_upd = 1'b1;
                illegal  = 1'b0;
            end
            is_mov: begin
                alu_op  = ALU_PASS_B;
                writes  = 1'b1;
                illegal = 1'b0;
            end
            is_cmp: begin
                alu_op   = ALU_CMP;
                flag_upd = 1'b1;
                illegal  = 1'b0;
            end
            is_addi: begin
                alu_op   = ALU_ADD;
                imm_sel  = 1'b1;
                writes   = 1'b1;
                flag_upd = 1'b1;
                illegal  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Four-state decode controller: accept, decode, execute, write back.
// Ports: clk, reset (sync, active-low), instr/instr_valid/instr_ready
// handshake, regfile addresses, ALU controls, imm_out, alu_flags in,
// wr_en/wr_addr, flags/cin, illegal. IDEC_RETIRE_CNT_EN adds retire_cnt.
module instr_decode_ctrl
    import instr_decode_ctrl_pkg::*;
#(
    parameter bit IMM_SEXT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  ra_addr,
    output logic [3:0]  rb_addr,
    output logic [1:0]  alu_op,
    output logic        imm_sel,
    output logic [15:0] imm_out,
    input  logic [4:0]  alu_flags,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [4:0]  flags,
    output logic        cin,
`ifdef IDEC_RETIRE_CNT_EN
    output logic [15:0] retire_cnt,
`endif
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    alu_op_e     alu_op_q, alu_op_d;
    logic        imm_sel_q, imm_sel_d;
    logic [15:0] imm_q, imm_d;
    logic        writes_q, writes_d;
    logic        fupd_q, fupd_d;
    logic        bad_q, bad_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [4:0]  flags_q, flags_d;
    logic        illegal_q, illegal_d;
    logic [15:0] cnt_q, cnt_d;

    alu_op_e     dec_op;
    logic        dec_isel;
    logic        dec_wr;
    logic        dec_fupd;
    logic        dec_bad;
    logic [15:0] dec_imm;

    idec_field_decode #(
        .IMM_SEXT (IMM_SEXT)
    ) u_dec (
        .instr    (instr),
        .alu_op   (dec_op),
        .imm_sel  (dec_isel),
        .writes   (dec_wr),
        .flag_upd (dec_fupd),
        .illegal  (dec_bad),
        .imm_out  (dec_imm)
    );

    // Decode happens on the accept edge so the controls are already
    // valid during DECODE and simply hold afterwards.
    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        alu_op_d  = alu_op_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        writes_d  = writes_q;
        fupd_d    = fupd_q;
        bad_d     = bad_q;
        wr_addr_d = wr_addr_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d   = S_DECODE;
                    ra_d      = instr[11:8];
                    rb_d      = instr[3:0];
                    alu_op_d  = dec_op;
                    imm_sel_d = dec_isel;
                    imm_d     = dec_imm;
                    writes_d  = dec_wr;
                    fupd_d    = dec_fupd;
                    bad_d     = dec_bad;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d   = S_WB;
                wr_en_d   = writes_q;
                illegal_d = bad_q;
                if (fupd_q) flags_d = alu_flags;
                if (writes_q) wr_addr_d = ra_q;
            end
            S_WB: begin
                state_d = S_IDLE;
                if (!bad_q) cnt_d = cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ra_q      <= 4'd0;
            rb_q      <= 4'd0;
            alu_op_q  <= ALU_NOP;
            imm_sel_q <= 1'b0;
            imm_q     <= 16'd0;
            writes_q  <= 1'b0;
            fupd_q    <= 1'b0;
            bad_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            flags_q   <= 5'd0;
            illegal_q <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            alu_op_q  <= alu_op_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            writes_q  <= writes_d;
            fupd_q    <= fupd_d;
            bad_q     <= bad_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign ra_addr     = ra_q;
    assign rb_addr     = rb_q;
    assign alu_op      = alu_op_q;
    assign imm_sel     = imm_sel_q;
    assign imm_out     = imm_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign flags       = flags_q;
    assign cin         = flags_q[3];
    assign illegal     = illegal_q;

`ifdef IDEC_RETIRE_CNT_EN
    assign retire_cnt = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Self-checking bench for instr_decode_ctrl: per-scenario tasks plus a
// retire scoreboard; a second instance checks the zero-extend build.
module tb_instr_decode_ctrl;

    typedef struct packed {
        logic [1:0] op;
        logic       isel;
        logic       wr;
        logic       fu;
        logic       bad;
    } exp_t;

    typedef struct packed {
        logic [3:0] addr;
        logic       wr;
        logic       bad;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [4:0]  alu_flags;
    logic        instr_ready;
    logic [3:0]  ra_addr, rb_addr, wr_addr;
    logic [1:0]  alu_op;
    logic        imm_sel, wr_en, cin, illegal;
    logic [15:0] imm_out;
    logic [4:0]  flags;
    logic        z_ready, z_isel, z_wr_en, z_cin, z_illegal;
    logic [3:0]  z_ra, z_rb, z_wa;
    logic [1:0]  z_op;
    logic [15:0] z_imm;
    logic [4:0]  z_flags;
`ifdef IDEC_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
    logic [15:0] z_cnt;
`endif

    int          vectors;
    int          miscompares;
    logic [4:0]  exp_flags;
    logic [15:0] exp_cnt;
    sb_t         sbq[$];

    instr_decode_ctrl #(.IMM_SEXT(1'b1)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .alu_op(alu_op),
        .imm_sel(imm_sel), .imm_out(imm_out), .alu_flags(alu_flags),
        .wr_en(wr_en), .wr_addr(wr_addr), .flags(flags), .cin(cin),
`ifdef IDEC_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .illegal(illegal)
    );

    instr_decode_ctrl #(.IMM_SEXT(1'b0)) dut_z (
        .clk(clk), .reset(reset), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(z_ready),
        .ra_addr(z_ra), .rb_addr(z_rb), .alu_op(z_op),
        .imm_sel(z_isel), .imm_out(z_imm), .alu_flags(alu_flags),
        .wr_en(z_wr_en), .wr_addr(z_wa), .flags(z_flags), .cin(z_cin),
`ifdef IDEC_RETIRE_CNT_EN
        .retire_cnt(z_cnt),
`endif
        .illegal(z_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] i);
        exp_t m;
        m = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
        if (i[15:12] == 4'h0 && i[7:4] == 4'h5) m = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        else if (i[15:12] == 4'h0 && i[7:4] == 4'hD) m = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
        else if (i[15:12] == 4'h0 && i[7:4] == 4'hB) m = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
        else if (i[15:12] == 4'h5) m = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        return m;
    endfunction

    function automatic logic [15:0] bext(input logic [7:0] b, input bit s);
        return s ? {{8{b[7]}}, b} : {8'h00, b};
    endfunction

    // Scoreboard: every wr_en/illegal pulse must match the oldest entry.
    always @(negedge clk) begin
        sb_t e;
        if (reset === 1'b1 && (wr_en === 1'b1 || illegal === 1'b1)) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL retire_unexpected wr_en=%0b illegal=%0b required none",
                         wr_en, illegal);
            end else begin
                e = sbq.pop_front();
                if ({wr_en, illegal} !== {e.wr, e.bad} ||
                    (e.wr && wr_addr !== e.addr)) begin
                    miscompares++;
                    $display("FAIL retire wr_en/illegal/addr=%b/%b/%h required %b/%b/%h",
                             wr_en, illegal, wr_addr, e.wr, e.bad, e.addr);
                end
            end
        end
    end

    task automatic run_instr(input logic [15:0] iw, input logic [4:0] af,
                             input bit hold);
        exp_t        m;
        logic [26:0] ed;
        int          n;
        m  = model(iw);
        ed = {iw[11:8], iw[3:0], m.op, m.isel, bext(iw[7:0], 1'b1)};
        n  = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (instr_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout got=%b required 1", instr_ready);
            return;
        end
        instr       = iw;
        instr_valid = 1'b1;
        if (m.wr || m.bad) sbq.push_back('{iw[11:8], m.wr, m.bad});
        @(posedge clk); #1;
        if (hold) instr = 16'h0150;
        else instr_valid = 1'b0;
        vectors++;
        if ({ra_addr, rb_addr, alu_op, imm_sel, imm_out} !== ed ||
            instr_ready !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL decode %h fields=%h rdy=%b we=%b required %h 0 0", iw,
                     {ra_addr, rb_addr, alu_op, imm_sel, imm_out},
                     instr_ready, wr_en, ed);
        end
        @(posedge clk); #1;
        alu_flags = af;
        vectors++;
        if ({ra_addr, rb_addr, alu_op, imm_sel, imm_out} !== ed ||
            flags !== exp_flags || instr_ready !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL exec %h fields=%h flags=%h rdy=%b required %h %h 0", iw,
                     {ra_addr, rb_addr, alu_op, imm_sel, imm_out}, flags,
                     instr_ready, ed, exp_flags);
        end
        @(posedge clk); #1;
        if (m.fu) exp_flags = af;
        vectors++;
        if (flags !== exp_flags || cin !== exp_flags[3] || wr_en !== m.wr ||
            illegal !== m.bad || instr_ready !== 1'b0 ||
            {ra_addr, rb_addr, alu_op, imm_sel, imm_out} !== ed) begin
            miscompares++;
            $display("FAIL wb %h flags=%h cin=%b we=%b ill=%b rdy=%b required %h %b %b %b 0",
                     iw, flags, cin, wr_en, illegal, instr_ready,
                     exp_flags, exp_flags[3], m.wr, m.bad);
        end
        @(posedge clk); #1;
        if (hold) instr_valid = 1'b0;
        if (!m.bad) exp_cnt = exp_cnt + 16'd1;
        vectors++;
        if (instr_ready !== 1'b1 || wr_en !== 1'b0 || illegal !== 1'b0 ||
            sbq.size() != 0 || flags !== exp_flags ||
            {ra_addr, rb_addr, alu_op, imm_sel, imm_out} !== ed) begin
            miscompares++;
            $display("FAIL idle %h rdy=%b we=%b ill=%b pend=%0d flags=%h required 1 0 0 0 %h",
                     iw, instr_ready, wr_en, illegal, sbq.size(), flags, exp_flags);
        end
`ifdef IDEC_RETIRE_CNT_EN
        vectors++;
        if (retire_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL retire_cnt got=%h required %h", retire_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        alu_flags   = 5'd0;
        exp_flags   = 5'd0;
        exp_cnt     = 16'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({flags, wr_en, illegal, alu_op, imm_sel, ra_addr, rb_addr,
             wr_addr, imm_out} !== {5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 12'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_state flags=%h we=%b ill=%b op=%b isel=%b ra=%h rb=%h wa=%h imm=%h required 0 0 0 11 0 0 0 0 0",
                     flags, wr_en, illegal, alu_op, imm_sel, ra_addr, rb_addr,
                     wr_addr, imm_out);
        end
        reset = 1'b1;
        vectors++;
        if (instr_ready !== 1'b1 || flags !== 5'd0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release rdy=%b flags=%h we=%b required 1 0 0",
                     instr_ready, flags, wr_en);
        end
        @(posedge clk); #1;
        vectors++;
        if (instr_ready !== 1'b1 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold rdy=%b we=%b required 1 0", instr_ready, wr_en);
        end
    endtask

    task automatic test_addi();
        run_instr(16'h5001, 5'h04, 1'b0);
    endtask

    task automatic test_add_mov();
        run_instr(16'h0150, 5'b01000, 1'b0);
        vectors++;
        if (flags !== 5'b01000 || cin !== 1'b1) begin
            miscompares++;
            $display("FAIL add_flags flags=%b cin=%b required 01000 1", flags, cin);
        end
        run_instr(16'h02D1, 5'h17, 1'b0);
        vectors++;
        if (flags !== 5'b01000) begin
            miscompares++;
            $display("FAIL mov_keeps_flags flags=%b required 01000", flags);
        end
    endtask

    task automatic test_cmp_self();
        run_instr(16'h03B4, 5'h15, 1'b0);
        run_instr(16'h0FDF, 5'h0A, 1'b0);
    endtask

    task automatic test_imm_ext();
        run_instr(16'h50FF, 5'h11, 1'b0);
        vectors++;
        if (imm_out !== 16'hFFFF || z_imm !== 16'h00FF) begin
            miscompares++;
            $display("FAIL imm_ext sext=%h zext=%h required FFFF 00FF", imm_out, z_imm);
        end
    endtask

    task automatic test_illegal_hold();
        run_instr(16'h3000, 5'h1F, 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (instr_ready !== 1'b1 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL no_extra_accept rdy=%b pend=%0d required 1 0",
                     instr_ready, sbq.size());
        end
        run_instr(16'h0000, 5'h1F, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] tbl [8];
        tbl = '{16'h0150, 16'h5A80, 16'h07B3, 16'h0EDC,
                16'h6123, 16'h0C5C, 16'h0F0F, 16'h5F7F};
        for (int k = 0; k < 10; k++) begin
            run_instr(tbl[$urandom_range(7, 0)], 5'($urandom_range(31, 0)), 1'b0);
        end
    endtask

    task automatic test_abort();
        instr       = 16'h0150;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        alu_flags = 5'h1F;
        reset     = 1'b0;
        @(posedge clk); #1;
        exp_flags = 5'd0;
        exp_cnt   = 16'd0;
        vectors++;
        if (flags !== 5'd0 || wr_en !== 1'b0 || instr_ready !== 1'b1 ||
            alu_op !== 2'b11) begin
            miscompares++;
            $display("FAIL abort flags=%h we=%b rdy=%b op=%b required 0 0 1 11",
                     flags, wr_en, instr_ready, alu_op);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (flags !== 5'd0 || wr_en !== 1'b0 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_after flags=%h we=%b rdy=%b required 0 0 1",
                     flags, wr_en, instr_ready);
        end
        run_instr(16'h5001, 5'h02, 1'b0);
        run_instr(16'h02D1, 5'h1F, 1'b0);
`ifdef IDEC_RETIRE_CNT_EN
        vectors++;
        if (retire_cnt !== 16'h0002) begin
            miscompares++;
            $display("FAIL retire_two got=%h required 0002", retire_cnt);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_addi();
        test_add_mov();
        test_cmp_self();
        test_imm_ext();
        test_illegal_hold();
        test_back_to_back();
        test_abort();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_retires got=%0d required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 Parameter IMM_SEXT, default 1: 1 = sign-extend the 8-bit immediate to 16 bits, 0 = zero-extend.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 instr  input  16  instruction word: [15:12] op, [11:8] rdest, [7:4] ext, [3:0] rsrc/imm_lo.
REQ-005 instr_valid  input  1  instr is valid this cycle.
REQ-006 instr_ready  output  1  block accepts instr this cycle.
REQ-007 ra_addr  output  4  register-file read port A address (rdest).
REQ-008 rb_addr  output  4  register-file read port B address (rsrc).
REQ-009 alu_op  output  2  00 ADD, 01 PASS_B (MOV), 10 CMP (subtract, flags only), 11 NOP.
REQ-010 imm_sel  output  1  1 = ALU B operand is imm_out, not the register-file read.
REQ-011 imm_out  output  16  extended immediate built from instr[7:0].
REQ-012 alu_flags  input  5  ALU flag result; bit 3 is carry.
REQ-013 wr_en  output  1  register-file write strobe, one-cycle pulse.
REQ-014 wr_addr  output  4  register-file write address.
REQ-015 flags  output  5  architected flags register.
REQ-016 cin  output  1  equals flags[3]; drives ALU carry-in.
REQ-017 illegal  output  1  one-cycle pulse when an undecodable instruction retires.

Function
REQ-018 Handshake: an instruction is accepted on a rising edge with instr_valid=1 and instr_ready=1. instr_ready=1 only in IDLE.
REQ-019 FSM states are IDLE, DECODE, EXEC and WB. IDLE->DECODE on accept. DECODE->EXEC and EXEC->WB are unconditional. WB->IDLE unconditional.
REQ-020 The instruction is latched on accept. instr_valid/instr while not ready are ignored.
REQ-021 Decode: op=0000 with ext=0101 is ADD; op=0000 with ext=1101 is MOV; op=0000 with ext=1011 is CMP; op=0101 is ADDI (ra=rdest, imm=instr[7:0], imm_sel=1). Any other encoding is illegal and decodes to alu_op=NOP.
REQ-022 ra_addr, rb_addr, alu_op, imm_sel and imm_out hold stable from DECODE through WB; outside those states they hold their last values.
REQ-023 In EXEC, flags<=alu_flags for ADD, ADDI and CMP. MOV, NOP and illegal leave flags unchanged.
REQ-024 In WB, wr_en=1 and wr_addr=rdest for ADD, ADDI and MOV. wr_en=0 for CMP and illegal. illegal=1 in WB for illegal encodings.
REQ-025 Accept-to-wr_en latency is exactly 3 cycles. Throughput is one instruction per 4 cycles.
REQ-026 Writing to the same register as the source (e.g. MOV r15->r15) is legal and is handled normally.
REQ-027 Immediate width rule: imm_out = {{8{instr[7]&IMM_SEXT}}, instr[7:0]}.

Reset
REQ-028 While reset=0 at a rising edge: state=IDLE, flags=0, wr_en=0, illegal=0, alu_op=NOP, imm_sel=0, ra_addr=rb_addr=wr_addr=0, imm_out=0.
REQ-029 Reset asserted mid-instruction aborts it: no wr_en and no flags update occur for that instruction. instr_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-030 Macro IDEC_RETIRE_CNT_EN.
- Defined: adds output retire_cnt, 16 bits. It increments by 1 in WB for every non-illegal instruction, wraps 0xFFFF->0, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Structure
REQ-031 A shared package holds the op/ext encoding constants (OP_RTYPE=0000, OP_ADDI=0101, EXT_ADD=0101, EXT_MOV=1101, EXT_CMP=1011), the alu_op encodings and the FSM state enumeration. The existing instruction generator reuses the same package.
REQ-032 The combinational field decode is a sub-module, idec_field_decode (instr -> alu_op, imm_sel, writes, illegal). The FSM and registers stay in instr_decode_ctrl.

Verification
REQ-033 Reset low for 2 cycles, then release -> instr_ready=1, flags=0, wr_en=0 on the first cycle.
REQ-034 Accept 0x5001 (ADDI r0,#1) -> ra_addr=0, imm_sel=1, imm_out=0x0001, alu_op=ADD; wr_en=1 with wr_addr=0 exactly 3 cycles after accept.
REQ-035 Accept 0x0150 (ADD r1,r0) with alu_flags=01000 driven in EXEC -> flags=01000 and cin=1 after EXEC; wr_addr=1. A following 0x02D1 (MOV r1->r2) leaves flags=01000.
REQ-036 Accept 0x50FF with IMM_SEXT=1 -> imm_out=0xFFFF. With IMM_SEXT=0 -> imm_out=0x00FF.
REQ-037 Accept 0x3000 (illegal) -> illegal pulses in WB, wr_en stays 0, flags unchanged. Hold instr_valid=1 during DECODE/EXEC/WB -> no extra accept occurs.
REQ-038 Accept 0x0150, then drive reset=0 in EXEC -> no wr_en and flags=0. With IDEC_RETIRE_CNT_EN defined, retire_cnt counts 0x0002 after two legal instructions.
